dm_access_unit: RTL and testbench
=================================

Name: dm_access_unit

Overview:
- Load/store access unit between the CPU memory stage and the data-memory SRAM wrapper.
- Accepts one byte, halfword or word request per handshake and drives SRAM address, write data and active-low byte write enables.
- Handles the SRAM's 1-cycle read latency.
- Returns aligned, sign- or zero-extended load data, with backpressure buffering on the response side.

Parameters:
- ADDR_W, 32, request/SRAM byte-address width.
- DM_WORDS, 16384, SRAM depth in words. Only addr[15:2] is consumed downstream; documentation only.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  unit can accept a request this cycle.
- req_we  input  1  1 = store, 0 = load.
- req_funct3  input  3  RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
- req_addr  input  ADDR_W  byte address.
- req_wdata  input  32  store data, right-aligned.
- resp_valid  output  1  response available.
- resp_ready  input  1  consumer accepts response.
- resp_rdata  output  32  extended load data; 0 for stores.
- resp_err  output  1  misaligned access (see Optional Feature).
- dm_addr  output  ADDR_W  SRAM byte address.
- dm_wdata  output  32  lane-replicated store data.
- dm_web  output  4  per-byte write enable, active-low; 4'hF = read/no write.
- dm_rdata  input  32  SRAM read data, valid the cycle after the address.

Behaviour:
- Reset is synchronous, active when rst = 0. On reset:
  - state = IDLE;
  - resp_valid = 0, resp_rdata = 0, resp_err = 0;
  - hold register = 0.
- While rst = 0, dm_web is forced to 4'hF combinationally. A reset mid-transaction drops that transaction; any store already written stays written.
- States:
  - IDLE: no response pending.
  - RESP: response taken live from dm_rdata.
  - HOLD: response served from the hold register.
- Handshake:
  - req_ready = (state == IDLE) || (state == RESP && resp_ready).
  - A request is accepted when req_valid && req_ready.
  - In the accept cycle: dm_addr = req_addr, and dm_web/dm_wdata are driven combinationally. The SRAM samples on that edge.
  - When no request is accepted: dm_web = 4'hF and dm_addr holds its last value.
- Latency: resp_valid = 1 exactly one cycle after accept. Back-to-back accepts give one response per cycle.
- Transitions:
  - IDLE: accept → RESP.
  - RESP with resp_ready = 1: accept → RESP; no accept → IDLE.
  - RESP with resp_ready = 0: capture the extended response into the hold register → HOLD.
  - HOLD: resp_ready = 1 → IDLE. req_ready = 0 while in HOLD.
- Registered per accept: funct3, addr[1:0], we, err. Extraction in RESP uses these with dm_rdata.
- Store lane mapping:
  - SB: dm_wdata = {4{wdata[7:0]}}, dm_web = ~(4'b0001 << addr[1:0]).
  - SH: dm_wdata = {2{wdata[15:0]}}, dm_web = addr[1] ? 4'b0011 : 4'b1100.
  - SW: dm_wdata = wdata, dm_web = 4'b0000.
  - funct3[1:0] == 2'b11: treated as SW.
- Load extraction:
  - Byte = dm_rdata[8*off +: 8].
  - Half = dm_rdata[16*off[1] +: 16].
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - Load funct3 011/110/111: treated as LW.
- Stores still produce a response: resp_rdata = 0, acknowledging completion.

Optional Feature:
- Macro: DM_MISALIGN_ERR_EN.
- Defined:
  - Halfword access with addr[0] = 1, or word access with addr[1:0] ≠ 0, is misaligned.
  - A misaligned store forces dm_web = 4'hF (no write).
  - Response carries resp_err = 1 and resp_rdata = 0, with normal 1-cycle timing.
- Undefined:
  - resp_err is tied to 0.
  - Halfword ignores addr[0]; word ignores addr[1:0]; the access proceeds force-aligned.

Test Plan:
- Reset: rst = 0 for 3 cycles with req_valid = 1 → dm_web = 4'hF, resp_valid = 0, req_ready = 1 after release.
- SW 0x8000_00FF to 0x100, then LB at 0x100 and LBU at 0x100 → resp_rdata 0xFFFF_FFFF, then 0x0000_00FF, each 1 cycle after accept.
- SB 0xAB to 0x203 → dm_web = 4'b0111, dm_wdata = 0xABAB_ABAB. Then LW 0x200 → byte[31:24] = 0xAB, other bytes unchanged.
- Back-to-back LH 0x102 and LHU 0x102 over word 0x8001_7FFF with resp_ready = 1 → 0xFFFF_8001 then 0x0000_8001 on consecutive cycles.
- Backpressure: LW completes with resp_ready = 0 for 4 cycles while the SRAM address changes → resp_rdata stable, req_ready = 0, state HOLD. Releasing resp_ready → one handshake, then IDLE.
- DM_MISALIGN_ERR_EN: SW to 0x102 → dm_web = 4'hF, resp_err = 1, a later LW 0x100 shows the old data. Without the macro → write lands at 0x100, resp_err = 0.

Source files
------------

// File: rtl/dm_access_unit.sv
// Load/store access unit between the CPU memory stage and a 1-cycle-latency data SRAM.
// Optional misalignment detection is enabled with `define DM_MISALIGN_ERR_EN.
module dm_access_unit #(
    parameter int ADDR_W   = 32,
    parameter int DM_WORDS = 16384
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [31:0]       dm_wdata,
    output logic [3:0]        dm_web,
    input  logic [31:0]       dm_rdata,
    output logic [1:0]        state_dbg
);

    // The SRAM word index must fit inside the byte address.
    if (ADDR_W < $clog2(DM_WORDS) + 2) begin : g_bad_cfg
        $error("dm_access_unit: ADDR_W too small for DM_WORDS");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RESP = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        f3_q;
    logic [1:0]        off_q;
    logic              we_q;
    logic              err_q;
    logic [31:0]       hold_q;
    logic              hold_err_q;
    logic [ADDR_W-1:0] addr_q;

    logic              accept;
    logic              capture;
    logic              req_err;
    logic [3:0]        lane_web;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [31:0]       live_rdata;

    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // valid never waits on ready, and the payload is held stable until taken.
    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        capture   = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_d = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    req_ready = 1'b1;
                    state_d   = req_valid ? RESP : IDLE;
                end else begin
                    capture = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign accept    = req_valid && req_ready;
    assign state_dbg = state_q;

`ifdef DM_MISALIGN_ERR_EN
    always_comb begin
        case (req_funct3[1:0])
            2'b00:   req_err = 1'b0;
            2'b01:   req_err = req_addr[0];
            default: req_err = (req_addr[1:0] != 2'b00);
        endcase
    end
`else
    assign req_err = 1'b0;
`endif

    // Store lane steering; funct3[1:0] == 2'b11 falls through as a word.
    always_comb begin
        dm_wdata = req_wdata;
        lane_web = 4'b0000;
        case (req_funct3[1:0])
            2'b00: begin
                dm_wdata = {4{req_wdata[7:0]}};
                lane_web = ~(4'b0001 << req_addr[1:0]);
            end
            2'b01: begin
                dm_wdata = {2{req_wdata[15:0]}};
                lane_web = req_addr[1] ? 4'b0011 : 4'b1100;
            end
            default: ;
        endcase
    end

    assign dm_web  = (rst && accept && req_we && !req_err) ? lane_web : 4'hF;
    assign dm_addr = accept ? req_addr : addr_q;

    // Load extraction from the live SRAM output, using the registered request fields.
    always_comb begin
        byte_sel = dm_rdata[8*off_q +: 8];
        half_sel = dm_rdata[16*off_q[1] +: 16];
        case (f3_q)
            3'b000:  live_rdata = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  live_rdata = {{16{half_sel[15]}}, half_sel};
            3'b100:  live_rdata = {24'd0, byte_sel};
            3'b101:  live_rdata = {16'd0, half_sel};
            default: live_rdata = dm_rdata;
        endcase
        if (we_q || err_q) live_rdata = 32'd0;
    end

    always_comb begin
        resp_valid = 1'b0;
        resp_rdata = 32'd0;
        resp_err   = 1'b0;
        case (state_q)
            RESP: begin
                resp_valid = 1'b1;
                resp_rdata = live_rdata;
                resp_err   = err_q;
            end
            HOLD: begin
                resp_valid = 1'b1;
                resp_rdata = hold_q;
                resp_err   = hold_err_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            f3_q       <= 3'd0;
            off_q      <= 2'd0;
            we_q       <= 1'b0;
            err_q      <= 1'b0;
            hold_q     <= 32'd0;
            hold_err_q <= 1'b0;
            addr_q     <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                f3_q   <= req_funct3;
                off_q  <= req_addr[1:0];
                we_q   <= req_we;
                err_q  <= req_err;
                addr_q <= req_addr;
            end
            if (capture) begin
                hold_q     <= live_rdata;
                hold_err_q <= err_q;
            end
        end
    end

endmodule

// File: tb/tb_dm_access_unit.sv
// Directed bench for dm_access_unit with a behavioural byte-write SRAM (1-cycle read).
// Expectations follow DM_MISALIGN_ERR_EN when it is defined for the build.
module tb_dm_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_web;
    logic [31:0] dm_rdata;
    logic [1:0]  state_dbg;

    logic        garble;
    logic [31:0] mem [0:1023];
    int          n_checks = 0;
    int          n_fail   = 0;

    localparam logic [2:0] F_B  = 3'b000;
    localparam logic [2:0] F_H  = 3'b001;
    localparam logic [2:0] F_W  = 3'b010;
    localparam logic [2:0] F_BU = 3'b100;
    localparam logic [2:0] F_HU = 3'b101;

    dm_access_unit #(.ADDR_W(32), .DM_WORDS(16384)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .dm_addr    (dm_addr),
        .dm_wdata   (dm_wdata),
        .dm_web     (dm_web),
        .dm_rdata   (dm_rdata),
        .state_dbg  (state_dbg)
    );

    always #5 clk = ~clk;

    // garble inverts the read port so a stalled response must come from the hold register
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (!dm_web[b]) mem[dm_addr[11:2]][8*b +: 8] <= dm_wdata[8*b +: 8];
        end
        dm_rdata <= garble ? ~mem[dm_addr[11:2]] : mem[dm_addr[11:2]];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = d;
    endtask

    task automatic idle_req();
        req_valid = 1'b0;
        req_we    = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
        dm_rdata   = 32'd0;
        garble     = 1'b0;
        rst        = 1'b0;
        resp_ready = 1'b1;
        drive(1'b1, F_W, 32'h100, 32'h1234_5678);

        // Reset held with a store request pending: nothing may be written.
        repeat (3) begin
            @(negedge clk); #1;
            chk("rst_web", {28'd0, dm_web}, 32'hF);
            chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        end
        @(negedge clk);
        rst = 1'b1;
        idle_req();
        #1;
        chk("rel_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rel_resp_rdata", resp_rdata, 32'd0);
        chk("rel_resp_err", {31'd0, resp_err}, 32'd0);
        chk("rel_state", {30'd0, state_dbg}, 32'd0);
        chk("rel_mem", mem[32'h100 >> 2], 32'd0);

        // SW then LB / LBU back to back.
        @(negedge clk); drive(1'b1, F_W, 32'h100, 32'h8000_00FF); #1;
        chk("sw_web", {28'd0, dm_web}, 32'h0);
        chk("sw_wdata", dm_wdata, 32'h8000_00FF);
        chk("sw_addr", dm_addr, 32'h100);
        @(negedge clk); drive(1'b0, F_B, 32'h100, 32'd0); #1;
        chk("sw_resp_valid", {31'd0, resp_valid}, 32'd1);
        chk("sw_resp_rdata", resp_rdata, 32'd0);
        chk("lb_web", {28'd0, dm_web}, 32'hF);
        @(negedge clk); drive(1'b0, F_BU, 32'h100, 32'd0); #1;
        chk("lb_rdata", resp_rdata, 32'hFFFF_FFFF);
        @(negedge clk); idle_req(); #1;
        chk("lbu_rdata", resp_rdata, 32'h0000_00FF);
        chk("lbu_valid", {31'd0, resp_valid}, 32'd1);
        @(negedge clk); #1;
        chk("idle_valid", {31'd0, resp_valid}, 32'd0);
        chk("idle_state", {30'd0, state_dbg}, 32'd0);

        // Byte store into the top lane of a known word.
        @(negedge clk); drive(1'b1, F_W, 32'h200, 32'h1122_3344);
        @(negedge clk); drive(1'b1, F_B, 32'h203, 32'h0000_00AB); #1;
        chk("sb_web", {28'd0, dm_web}, 32'h7);
        chk("sb_wdata", dm_wdata, 32'hABAB_ABAB);
        @(negedge clk); drive(1'b0, F_W, 32'h200, 32'd0); #1;
        chk("sb_resp_rdata", resp_rdata, 32'd0);
        @(negedge clk); drive(1'b0, F_B, 32'h203, 32'd0); #1;
        chk("lw_after_sb", resp_rdata, 32'hAB22_3344);
        @(negedge clk); drive(1'b1, F_H, 32'h202, 32'h0000_5566); #1;
        chk("lb_203", resp_rdata, 32'hFFFF_FFAB);
        chk("sh_web", {28'd0, dm_web}, 32'h3);
        chk("sh_wdata", dm_wdata, 32'h5566_5566);

        // Back-to-back halfword loads.
        @(negedge clk); drive(1'b1, F_W, 32'h100, 32'h8001_7FFF);
        @(negedge clk); drive(1'b0, F_H, 32'h102, 32'd0);
        @(negedge clk); drive(1'b0, F_HU, 32'h102, 32'd0); #1;
        chk("lh_rdata", resp_rdata, 32'hFFFF_8001);
        @(negedge clk); drive(1'b0, F_H, 32'h100, 32'd0); #1;
        chk("lhu_rdata", resp_rdata, 32'h0000_8001);
        @(negedge clk); idle_req(); #1;
        chk("lh_low_rdata", resp_rdata, 32'h0000_7FFF);
        @(negedge clk); #1;

        // Backpressure: response must freeze while the SRAM read port shows garbage.
        @(negedge clk); resp_ready = 1'b0; drive(1'b0, F_W, 32'h100, 32'd0); #1;
        chk("bp_accept_ready", {31'd0, req_ready}, 32'd1);
        @(negedge clk); drive(1'b0, F_W, 32'h200, 32'd0); garble = 1'b1; #1;
        chk("bp_resp_live", resp_rdata, 32'h8001_7FFF);
        chk("bp_req_ready0", {31'd0, req_ready}, 32'd0);
        chk("bp_state_resp", {30'd0, state_dbg}, 32'd1);
        chk("bp_addr_hold0", dm_addr, 32'h100);
        repeat (3) begin
            @(negedge clk); #1;
            chk("bp_hold_rdata", resp_rdata, 32'h8001_7FFF);
            chk("bp_hold_valid", {31'd0, resp_valid}, 32'd1);
            chk("bp_hold_ready", {31'd0, req_ready}, 32'd0);
            chk("bp_hold_state", {30'd0, state_dbg}, 32'd2);
            chk("bp_hold_web", {28'd0, dm_web}, 32'hF);
            chk("bp_hold_addr", dm_addr, 32'h100);
        end
        @(negedge clk); resp_ready = 1'b1; idle_req(); #1;
        chk("bp_release_rdata", resp_rdata, 32'h8001_7FFF);
        @(negedge clk); garble = 1'b0; #1;
        chk("bp_done_valid", {31'd0, resp_valid}, 32'd0);
        chk("bp_done_state", {30'd0, state_dbg}, 32'd0);

        // Misaligned word store and halfword load.
        @(negedge clk); drive(1'b1, F_W, 32'h102, 32'hDEAD_BEEF); #1;
`ifdef DM_MISALIGN_ERR_EN
        chk("mis_sw_web", {28'd0, dm_web}, 32'hF);
`else
        chk("mis_sw_web", {28'd0, dm_web}, 32'h0);
`endif
        @(negedge clk); drive(1'b0, F_W, 32'h100, 32'd0); #1;
        chk("mis_sw_rdata", resp_rdata, 32'd0);
`ifdef DM_MISALIGN_ERR_EN
        chk("mis_sw_err", {31'd0, resp_err}, 32'd1);
`else
        chk("mis_sw_err", {31'd0, resp_err}, 32'd0);
`endif
        @(negedge clk); drive(1'b0, F_HU, 32'h101, 32'd0); #1;
        chk("mis_lw_err", {31'd0, resp_err}, 32'd0);
`ifdef DM_MISALIGN_ERR_EN
        chk("mis_lw_rdata", resp_rdata, 32'h8001_7FFF);
`else
        chk("mis_lw_rdata", resp_rdata, 32'hDEAD_BEEF);
`endif
        @(negedge clk); idle_req(); #1;
`ifdef DM_MISALIGN_ERR_EN
        chk("mis_lhu_rdata", resp_rdata, 32'd0);
        chk("mis_lhu_err", {31'd0, resp_err}, 32'd1);
`else
        chk("mis_lhu_rdata", resp_rdata, 32'h0000_BEEF);
        chk("mis_lhu_err", {31'd0, resp_err}, 32'd0);
`endif
        @(negedge clk); #1;
        chk("end_valid", {31'd0, resp_valid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
